// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the CPU fetch and data buses. One sequencer arbitrates
// between the two requesters, applies WAIT wait states and answers with a one-cycle ack.
`timescale 1ns/1ps
module cpu_mem_responder #(
    parameter int IADDR_W = 8,
    parameter int DADDR_W = 8,
    parameter int WAIT    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ireq,
    input  logic [15:0]        iaddr,
    output logic [23:0]        instr,
    output logic               iack,
    input  logic               dreq,
    input  logic [15:0]        daddr,
    input  logic               data_wr,
    input  logic [15:0]        data_out,
    output logic [15:0]        data_in,
    output logic               dack,
    output logic               err,
    output logic               busy,
    input  logic               prog_we,
    input  logic [IADDR_W-1:0] prog_addr,
    input  logic [23:0]        prog_data
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    localparam logic       SIDE_I   = 1'b0;
    localparam logic       SIDE_D   = 1'b1;
    localparam logic [2:0] WAIT_CNT = 3'(WAIT);

    logic [23:0] istore [0:(1<<IADDR_W)-1];
    logic [15:0] dstore [0:(1<<DADDR_W)-1];

    state_t      state_reg, state_next;
    logic [2:0]  wcnt_reg, wcnt_next;
    logic [15:0] addr_reg, addr_next;
    logic        side_reg, side_next;
    logic        wr_reg, wr_next;
    logic [15:0] wdata_reg, wdata_next;
    logic        last_grant_reg, last_grant_next;
    logic        iack_reg, dack_reg, err_reg;
    logic [23:0] instr_reg;
    logic [15:0] data_in_reg;
    logic        grant_i, grant_d;
    logic        resp, oor;
    logic [IADDR_W-1:0] iidx;
    logic [DADDR_W-1:0] didx;

    assign resp = (state_reg == ST_RESP);
    assign iidx = addr_reg[IADDR_W-1:0];
    assign didx = addr_reg[DADDR_W-1:0];
    // Any address bit above the store's index width makes the access out of range.
    assign oor  = (side_reg == SIDE_D) ? ((addr_reg >> DADDR_W) != 16'd0)
                                       : ((addr_reg >> IADDR_W) != 16'd0);

    always_comb begin
        state_next      = state_reg;
        wcnt_next       = wcnt_reg;
        addr_next       = addr_reg;
        side_next       = side_reg;
        wr_next         = wr_reg;
        wdata_next      = wdata_reg;
        last_grant_next = last_grant_reg;
        grant_i         = 1'b0;
        grant_d         = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // Requests are ignored in the ack cycle so a held req is not served twice.
                if (!prog_we && !iack_reg && !dack_reg) begin
                    if (dreq && (!ireq || last_grant_reg == SIDE_I)) begin
                        grant_d = 1'b1;
                    end else if (ireq) begin
                        grant_i = 1'b1;
                    end
                end
                if (grant_d || grant_i) begin
                    side_next       = grant_d ? SIDE_D : SIDE_I;
                    addr_next       = grant_d ? daddr : iaddr;
                    wr_next         = grant_d & data_wr;
                    wdata_next      = data_out;
                    last_grant_next = grant_d ? SIDE_D : SIDE_I;
                    wcnt_next       = WAIT_CNT;
                    state_next      = (WAIT > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                wcnt_next = wcnt_reg - 3'd1;
                if (wcnt_reg <= 3'd1) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            wcnt_reg       <= 3'd0;
            addr_reg       <= 16'd0;
            side_reg       <= SIDE_I;
            wr_reg         <= 1'b0;
            wdata_reg      <= 16'd0;
            last_grant_reg <= SIDE_I;
            iack_reg       <= 1'b0;
            dack_reg       <= 1'b0;
            err_reg        <= 1'b0;
            instr_reg      <= 24'd0;
            data_in_reg    <= 16'd0;
        end else begin
            state_reg      <= state_next;
            wcnt_reg       <= wcnt_next;
            addr_reg       <= addr_next;
            side_reg       <= side_next;
            wr_reg         <= wr_next;
            wdata_reg      <= wdata_next;
            last_grant_reg <= last_grant_next;
            iack_reg       <= resp && (side_reg == SIDE_I);
            dack_reg       <= resp && (side_reg == SIDE_D);
            err_reg        <= resp && oor;
            if (resp && side_reg == SIDE_I) begin
                instr_reg <= oor ? 24'd0 : istore[iidx];
            end
            if (resp && side_reg == SIDE_D && !wr_reg) begin
                data_in_reg <= oor ? 16'd0 : dstore[didx];
            end
        end
    end

    // Program load only lands while the sequencer is idle.
    always_ff @(posedge clk) begin
        if (state_reg == ST_IDLE && prog_we) begin
            istore[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && resp && side_reg == SIDE_D && wr_reg && !oor) begin
            dstore[didx] <= wdata_reg;
        end
    end

    assign instr   = instr_reg;
    assign iack    = iack_reg;
    assign data_in = data_in_reg;
    assign dack    = dack_reg;
    assign err     = err_reg;
    assign busy    = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: three instances with WAIT = 0, 1 and 3
// share one clock; each test drives one instance and checks hand-computed values.
`timescale 1ns/1ps
module tb_cpu_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]        rst;
    logic [2:0]        ireq, iack, dreq, data_wr, dack, err, busy, prog_we;
    logic [2:0][15:0]  iaddr, daddr, data_out, data_in;
    logic [2:0][23:0]  instr, prog_data;
    logic [2:0][7:0]   prog_addr;

    int checks = 0;
    int errors = 0;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        cpu_mem_responder #(
            .IADDR_W(8),
            .DADDR_W(8),
            .WAIT   ((gi == 0) ? 0 : ((gi == 1) ? 1 : 3))
        ) u_dut (
            .clk      (clk),
            .rst      (rst[gi]),
            .ireq     (ireq[gi]),
            .iaddr    (iaddr[gi]),
            .instr    (instr[gi]),
            .iack     (iack[gi]),
            .dreq     (dreq[gi]),
            .daddr    (daddr[gi]),
            .data_wr  (data_wr[gi]),
            .data_out (data_out[gi]),
            .data_in  (data_in[gi]),
            .dack     (dack[gi]),
            .err      (err[gi]),
            .busy     (busy[gi]),
            .prog_we  (prog_we[gi]),
            .prog_addr(prog_addr[gi]),
            .prog_data(prog_data[gi])
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input int k, input logic [7:0] a, input logic [23:0] d);
        prog_we[k] = 1'b1;
        prog_addr[k] = a;
        prog_data[k] = d;
        tick();
        prog_we[k] = 1'b0;
        $display("dut%0d prog istore[%0d] = %h", k, a, d);
    endtask

    // Issues one request, returns the cycles until the ack was seen and the err flag.
    task automatic access(input int k, input bit is_d, input bit wr, input logic [15:0] a,
                          input logic [15:0] wd, output int lat, output logic e);
        logic ack;
        lat = 0;
        ack = 1'b0;
        if (is_d) begin
            dreq[k] = 1'b1; daddr[k] = a; data_wr[k] = wr; data_out[k] = wd;
        end else begin
            ireq[k] = 1'b1; iaddr[k] = a;
        end
        while (lat < 30 && !ack) begin
            tick();
            lat++;
            ack = is_d ? dack[k] : iack[k];
        end
        e = err[k];
        ireq[k] = 1'b0;
        dreq[k] = 1'b0;
        $display("dut%0d %s addr=%h wd=%h lat=%0d err=%b instr=%h data_in=%h",
                 k, is_d ? (wr ? "store" : "load ") : "fetch", a, wd, lat, e, instr[k], data_in[k]);
        tick();
        check_eq("ack_one_cycle", {30'd0, iack[k], dack[k]}, 32'd0);
    endtask

    int   lat;
    logic e;
    int   n, both, dacks;
    logic [2:0] order;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = '1; ireq = '0; dreq = '0; data_wr = '0; prog_we = '0;
        iaddr = '0; daddr = '0; data_out = '0; prog_addr = '0; prog_data = '0;
        repeat (3) tick();
        for (int k = 0; k < 3; k++) begin
            check_eq("reset_outputs", {26'd0, iack[k], dack[k], err[k], busy[k], 2'b00}, 32'd0);
            check_eq("reset_instr", {8'd0, instr[k]}, 32'd0);
            check_eq("reset_data_in", {16'd0, data_in[k]}, 32'd0);
        end
        rst = '0;

        // WAIT=1 fetch: grant at the first edge, iack two edges later.
        prog(1, 8'd3, 24'hC12345);
        access(1, 1'b0, 1'b0, 16'd3, 16'd0, lat, e);
        check_eq("w1_fetch_lat", lat, 3);
        check_eq("w1_fetch_instr", {8'd0, instr[1]}, 32'h00C12345);
        check_eq("w1_fetch_err", {31'd0, e}, 0);

        // Round-robin on WAIT=0: tie right after reset goes to data first.
        prog(0, 8'd2, 24'h123456);
        ireq[0] = 1'b1; iaddr[0] = 16'd2;
        dreq[0] = 1'b1; daddr[0] = 16'd4; data_wr[0] = 1'b0;
        n = 0; both = 0; order = '0;
        for (int c = 0; c < 20 && n < 3; c++) begin
            tick();
            if (iack[0] && dack[0]) both++;
            if (iack[0]) begin order[n] = 1'b0; n++; end
            else if (dack[0]) begin order[n] = 1'b1; n++; end
        end
        ireq[0] = 1'b0; dreq[0] = 1'b0;
        $display("dut0 round-robin completions=%0d order(d=1)=%b%b%b", n, order[0], order[1], order[2]);
        tick();
        check_eq("rr_count", n, 3);
        check_eq("rr_order", {29'd0, order}, 32'b101);
        check_eq("rr_both_acks", both, 0);
        check_eq("rr_instr", {8'd0, instr[0]}, 32'h00123456);

        // WAIT=0 store then load of the same word.
        access(0, 1'b1, 1'b1, 16'd5, 16'hBEEF, lat, e);
        check_eq("w0_store_lat", lat, 2);
        access(0, 1'b1, 1'b0, 16'd5, 16'd0, lat, e);
        check_eq("w0_load_lat", lat, 2);
        check_eq("w0_load_data", {16'd0, data_in[0]}, 32'h0000BEEF);
        check_eq("w0_instr_held", {8'd0, instr[0]}, 32'h00123456);

        // Out-of-range data and fetch addresses.
        access(0, 1'b1, 1'b1, 16'd0, 16'h1234, lat, e);
        access(0, 1'b1, 1'b0, 16'h0100, 16'd0, lat, e);
        check_eq("oor_load_err", {31'd0, e}, 1);
        check_eq("oor_load_data", {16'd0, data_in[0]}, 32'd0);
        access(0, 1'b1, 1'b1, 16'h0100, 16'h5555, lat, e);
        check_eq("oor_store_err", {31'd0, e}, 1);
        access(0, 1'b1, 1'b0, 16'd0, 16'd0, lat, e);
        check_eq("oor_store_alias", {16'd0, data_in[0]}, 32'h00001234);
        check_eq("inrange_load_err", {31'd0, e}, 0);
        access(0, 1'b0, 1'b0, 16'h8002, 16'd0, lat, e);
        check_eq("oor_fetch_err", {31'd0, e}, 1);
        check_eq("oor_fetch_instr", {8'd0, instr[0]}, 32'd0);

        // WAIT=3: reset in the second wait cycle aborts a store.
        access(2, 1'b1, 1'b1, 16'd7, 16'h1111, lat, e);
        check_eq("w3_store_lat", lat, 5);
        access(2, 1'b1, 1'b0, 16'd7, 16'd0, lat, e);
        check_eq("w3_load_data", {16'd0, data_in[2]}, 32'h00001111);
        dreq[2] = 1'b1; daddr[2] = 16'd7; data_wr[2] = 1'b1; data_out[2] = 16'h2222;
        tick();
        tick();
        check_eq("abort_busy_before", {31'd0, busy[2]}, 1);
        rst[2] = 1'b1;
        dreq[2] = 1'b0;
        tick();
        $display("dut2 reset during wait: busy=%b dack=%b data_in=%h", busy[2], dack[2], data_in[2]);
        check_eq("abort_outputs", {28'd0, iack[2], dack[2], err[2], busy[2]}, 32'd0);
        check_eq("abort_data_in", {16'd0, data_in[2]}, 32'd0);
        rst[2] = 1'b0;
        dacks = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (dack[2]) dacks++;
        end
        check_eq("abort_no_dack", dacks, 0);
        access(2, 1'b1, 1'b0, 16'd7, 16'd0, lat, e);
        check_eq("abort_store_dropped", {16'd0, data_in[2]}, 32'h00001111);

        // prog_we while busy is ignored; the same write when idle lands.
        prog(1, 8'd9, 24'h111111);
        dreq[1] = 1'b1; daddr[1] = 16'd1; data_wr[1] = 1'b0;
        tick();
        check_eq("prog_busy_high", {31'd0, busy[1]}, 1);
        prog_we[1] = 1'b1; prog_addr[1] = 8'd9; prog_data[1] = 24'hABCDEF;
        tick();
        prog_we[1] = 1'b0;
        n = 0;
        while (n < 10 && !dack[1]) begin
            tick();
            n++;
        end
        check_eq("prog_busy_dack", {31'd0, dack[1]}, 1);
        dreq[1] = 1'b0;
        $display("dut1 prog_we pulsed while busy, data load completed");
        tick();
        access(1, 1'b0, 1'b0, 16'd9, 16'd0, lat, e);
        check_eq("prog_busy_ignored", {8'd0, instr[1]}, 32'h00111111);
        prog(1, 8'd9, 24'hABCDEF);
        access(1, 1'b0, 1'b0, 16'd9, 16'd0, lat, e);
        check_eq("prog_idle_written", {8'd0, instr[1]}, 32'h00ABCDEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
